huf_bit_packer: RTL and testbench

- Downstream of the Huffman encoder top. Consumes its serial code bitstream (one bit per cycle when qualified) and packs the bits MSB-first into bytes for a byte-wide sink.
- One-byte hold register plus a small output FIFO. This lets the final byte of a message carry a Last flag and a pad count on Flush.
- Sustains one input bit per cycle. Back-pressure comes from the sink's Byte_Ready.

---
 rtl/huf_bit_packer.sv | 171 +++++++++++++++++
 tb/tb_huf_bit_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/huf_bit_packer.sv
// Packs a serial Huffman code bitstream MSB-first into bytes and queues them
// for a byte-wide sink, tagging the final byte of each message with Last and a pad count.
module huf_bit_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Bit_in,
    input  logic             Bit_Valid,
    input  logic             Flush,
    input  logic             Byte_Ready,
    output logic [7:0]       Byte_out,
    output logic             Byte_Valid,
    output logic             Byte_Last,
    output logic [2:0]       Pad_Bits,
    output logic [CNT_W-1:0] Bit_Count,
    output logic             Busy,
    output logic             Flush_Done,
    output logic             Overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ACC, F_HOLD, F_PART, F_DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       sr_q, sr_d;
    logic [2:0]       n_q, n_d;
    logic [7:0]       h_q, h_d;
    logic             hv_q, hv_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             ovf_q, ovf_d;

    // FIFO entry layout: {last, pad[2:0], data[7:0]}
    logic [11:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;

    logic             push, pop, full, can_push;
    logic [11:0]      push_word;

    assign pop      = (cnt_q != '0) && Byte_Ready;
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign can_push = !full || pop;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        n_d       = n_q;
        h_d       = h_q;
        hv_d      = hv_q;
        bcnt_d    = bcnt_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_word = '0;

        case (state_q)
            ACC: begin
                if (Bit_Valid) begin
                    sr_d[3'd7 - n_q] = Bit_in;
                    n_d = n_q + 3'd1;
                    if (bcnt_q != '1) begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                    // Completed byte moves to the hold register; the previous
                    // hold byte is known not to be last, so it can be queued now.
                    if (n_q == 3'd7) begin
                        h_d  = {sr_q[7:1], Bit_in};
                        sr_d = '0;
                        hv_d = 1'b1;
                        if (hv_q) begin
                            if (can_push) begin
                                push      = 1'b1;
                                push_word = {1'b0, 3'd0, h_q};
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end
                if (Flush) begin
                    state_d = F_HOLD;
                end
            end
            F_HOLD: begin
                if (hv_q) begin
                    if (can_push) begin
                        push      = 1'b1;
                        push_word = {(n_q == 3'd0), 3'd0, h_q};
                        hv_d      = 1'b0;
                        state_d   = (n_q == 3'd0) ? F_DONE : F_PART;
                    end
                end else begin
                    state_d = (n_q == 3'd0) ? F_DONE : F_PART;
                end
            end
            F_PART: begin
                if (can_push) begin
                    push      = 1'b1;
                    push_word = {1'b1, 3'd0 - n_q, sr_q};
                    sr_d      = '0;
                    n_d       = '0;
                    state_d   = F_DONE;
                end
            end
            F_DONE: begin
                bcnt_d  = '0;
                state_d = ACC;
            end
            default: state_d = ACC;
        endcase

        if (state_q != ACC && Bit_Valid) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ACC;
            sr_q    <= '0;
            n_q     <= '0;
            h_q     <= '0;
            hv_q    <= 1'b0;
            bcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            n_q     <= n_d;
            h_q     <= h_d;
            hv_q    <= hv_d;
            bcnt_q  <= bcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_word;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign Byte_Valid = (cnt_q != '0);
    assign {Byte_Last, Pad_Bits, Byte_out} = mem_q[rd_q];
    assign Bit_Count  = bcnt_q;
    assign Busy       = (state_q != ACC);
    assign Flush_Done = (state_q == F_DONE);
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_huf_bit_packer.sv
// Self-checking bench for huf_bit_packer: table-driven messages plus hand-written
// back-pressure, overflow and asynchronous-reset sequences, with a byte scoreboard.
module tb_huf_bit_packer;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Bit_in;
    logic             Bit_Valid;
    logic             Flush;
    logic             Byte_Ready;
    logic [7:0]       Byte_out;
    logic             Byte_Valid;
    logic             Byte_Last;
    logic [2:0]       Pad_Bits;
    logic [CNT_W-1:0] Bit_Count;
    logic             Busy;
    logic             Flush_Done;
    logic             Overflow;

    huf_bit_packer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Bit_in    (Bit_in),
        .Bit_Valid (Bit_Valid),
        .Flush     (Flush),
        .Byte_Ready(Byte_Ready),
        .Byte_out  (Byte_out),
        .Byte_Valid(Byte_Valid),
        .Byte_Last (Byte_Last),
        .Pad_Bits  (Pad_Bits),
        .Bit_Count (Bit_Count),
        .Busy      (Busy),
        .Flush_Done(Flush_Done),
        .Overflow  (Overflow)
    );

    always #5 Clk = ~Clk;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic [31:0] pat;
        int unsigned nbits;
        int unsigned nbytes;
        logic [7:0]  last_data;
        logic [2:0]  last_pad;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted byte is compared with the oldest expected one.
    always @(negedge Clk) begin
        if (!Reset && Byte_Valid && Byte_Ready) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_byte: got data 0x%0h last %0d pad %0d, expected no byte (t=%0t)",
                         Byte_out, Byte_Last, Pad_Bits, $time);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("byte_data", 32'(Byte_out), 32'(e[7:0]));
                chk("byte_last", 32'(Byte_Last), 32'(e[11]));
                chk("pad_bits", 32'(Pad_Bits), 32'(e[10:8]));
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] pat, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            Bit_Valid = 1'b1;
            Bit_in    = pat[31-i];
            tick();
        end
        Bit_Valid = 1'b0;
        Bit_in    = 1'b0;
    endtask

    task automatic do_flush(output int unsigned busy, output int unsigned done_at);
        busy    = 0;
        done_at = 0;
        Flush   = 1'b1;
        tick();
        Flush = 1'b0;
        for (int unsigned c = 1; c <= 60 && done_at == 0; c++) begin
            @(negedge Clk);
            if (Busy) busy++;
            if (Flush_Done) done_at = c;
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic drain(input int unsigned budget);
        for (int unsigned c = 0; c < budget && exp_q.size() != 0; c++) begin
            tick();
        end
        chk("drain_all_expected", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
        chk("no_extra_byte", 32'(Byte_Valid), 32'd0);
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        Bit_Valid = 1'b0;
        Bit_in    = 1'b0;
        Flush     = 1'b0;
        #12;
        Reset = 1'b0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned busy, done_at, first, exp_busy;
        logic seen;

        vt[0] = '{32'hB1F0_0000, 16, 2, 8'hF0, 3'd0};
        vt[1] = '{32'hAAA0_0000, 11, 2, 8'hA0, 3'd5};
        vt[2] = '{32'h0000_0000,  0, 0, 8'h00, 3'd0};
        vt[3] = '{32'hE000_0000,  3, 1, 8'hE0, 3'd5};
        vt[4] = '{32'h5A00_0000,  8, 1, 8'h5A, 3'd0};
        vt[5] = '{32'h8000_0000,  1, 1, 8'h80, 3'd7};
        vt[6] = '{32'h1235_0000, 15, 2, 8'h34, 3'd1};
        vt[7] = '{32'hDEAD_BE00, 24, 3, 8'hBE, 3'd0};

        Reset      = 1'b1;
        Bit_in     = 1'b0;
        Bit_Valid  = 1'b0;
        Flush      = 1'b0;
        Byte_Ready = 1'b1;
        #1;
        chk("reset_outputs",
            32'({Byte_out, Byte_Valid, Byte_Last, Pad_Bits, Bit_Count, Busy, Flush_Done, Overflow}),
            32'd0);
        do_reset();

        // Table-driven messages with the sink always ready.
        foreach (vt[v]) begin
            for (int unsigned k = 0; k + 1 < vt[v].nbytes; k++) begin
                exp_q.push_back({1'b0, 3'd0, vt[v].pat[31-8*k -: 8]});
            end
            if (vt[v].nbytes > 0) begin
                exp_q.push_back({1'b1, vt[v].last_pad, vt[v].last_data});
            end
            first = (vt[v].nbits < 8) ? vt[v].nbits : 8;
            send_bits(vt[v].pat, first);
            chk("no_early_byte", 32'(Byte_Valid), 32'd0);
            send_bits(vt[v].pat << first, vt[v].nbits - first);
            chk("bit_count", 32'(Bit_Count), 32'(vt[v].nbits));
            do_flush(busy, done_at);
            exp_busy = (vt[v].nbits % 8 != 0) ? 3 : 2;
            chk("flush_done_cycle", done_at, exp_busy);
            chk("busy_cycles", busy, exp_busy);
            chk("bit_count_cleared", 32'(Bit_Count), 32'd0);
            drain(40);
            chk("overflow_clear", 32'(Overflow), 32'd0);
        end

        // Overflow: sink stalled while FIFO_DEPTH+2 bytes arrive.
        do_reset();
        Byte_Ready = 1'b0;
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            exp_q.push_back({1'b0, 3'd0, 8'hFF});
        end
        send_bits(32'hFFFF_FFFF, 32);
        send_bits(32'hFFFF_FFFF, 8 * (FIFO_DEPTH + 2) - 32);
        chk("overflow_set", 32'(Overflow), 32'd1);
        chk("fifo_full_valid", 32'(Byte_Valid), 32'd1);
        Byte_Ready = 1'b1;
        drain(40);
        exp_q.push_back({1'b1, 3'd0, 8'hFF});
        do_flush(busy, done_at);
        chk("ovf_flush_done_cycle", done_at, 32'd2);
        drain(40);
        chk("overflow_sticky", 32'(Overflow), 32'd1);

        // Flush stalls on a full FIFO until the sink frees space.
        do_reset();
        Byte_Ready = 1'b0;
        exp_q.push_back({1'b0, 3'd0, 8'hC3});
        exp_q.push_back({1'b0, 3'd0, 8'h3C});
        exp_q.push_back({1'b1, 3'd0, 8'h5A});
        send_bits(32'hC33C_5A00, 24);
        do_flush(busy, done_at);
        chk("prefill_flush_done", done_at, 32'd2);
        exp_q.push_back({1'b0, 3'd0, 8'h9E});
        exp_q.push_back({1'b0, 3'd0, 8'h7B});
        exp_q.push_back({1'b1, 3'd4, 8'hD0});
        send_bits(32'h9E7B_D000, 20);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        repeat (6) tick();
        chk("busy_while_stalled", 32'(Busy), 32'd1);
        chk("no_done_while_stalled", 32'(Flush_Done), 32'd0);
        Byte_Ready = 1'b1;
        seen = 1'b0;
        for (int unsigned c = 0; c < 40 && !seen; c++) begin
            @(negedge Clk);
            if (Flush_Done) seen = 1'b1;
            @(posedge Clk);
            #1;
        end
        chk("flush_done_after_stall", 32'(seen), 32'd1);
        drain(40);
        chk("stall_no_overflow", 32'(Overflow), 32'd0);

        // Asynchronous reset mid-message with a byte queued and Overflow set.
        do_reset();
        Byte_Ready = 1'b0;
        send_bits(32'h3C00_0000, 8);
        Flush = 1'b1;
        tick();
        Flush     = 1'b0;
        Bit_Valid = 1'b1;
        tick();
        Bit_Valid = 1'b0;
        tick();
        tick();
        chk("busy_bit_overflow", 32'(Overflow), 32'd1);
        chk("queued_before_reset", 32'(Byte_Valid), 32'd1);
        send_bits(32'hFFF8_0000, 13);
        chk("bit_count_13", 32'(Bit_Count), 32'd13);
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(Byte_Valid), 32'd0);
        chk("async_rst_count", 32'(Bit_Count), 32'd0);
        chk("async_rst_overflow", 32'(Overflow), 32'd0);
        chk("async_rst_busy", 32'(Busy), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        tick();
        Byte_Ready = 1'b1;
        exp_q.push_back({1'b1, 3'd0, 8'h96});
        send_bits(32'h9600_0000, 8);
        do_flush(busy, done_at);
        chk("post_reset_flush_done", done_at, 32'd2);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
